// File: rtl/ode_arith_pkg.sv
// Types and helpers shared by the ODE-solver arithmetic units.
// Holds the serial adder FSM state encoding and the counter-width function.
package ode_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Never returns less than 1, so a counter built from it always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_sub_add2_slice.sv
// Two-bit ripple slice built from two chained 1-bit full adders.
module add2_slice (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       cin_i,
  output logic [1:0] sum_o,
  output logic       cout_o
);

  logic c1;

  assign sum_o[0] = a_i[0] ^ b_i[0] ^ cin_i;
  assign c1       = (a_i[0] & b_i[0]) | (cin_i & (a_i[0] ^ b_i[0]));
  assign sum_o[1] = a_i[1] ^ b_i[1] ^ c1;
  assign cout_o   = (a_i[1] & b_i[1]) | (c1 & (a_i[1] ^ b_i[1]));

endmodule

// File: rtl/serial_add_sub.sv
// Iterative signed add/subtract: two bits per clock over DATA_WIDTH/2 cycles,
// with valid/ready handshakes on the request and result sides.
module serial_add_sub
  import ode_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  cout
);

  localparam int STEPS = DATA_WIDTH / 2;
  localparam int CW    = clog2(STEPS);
  localparam int MSB   = DATA_WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   opa_q, opb_q, res_q;
  logic [CW-1:0]           cnt_q;
  logic                    carry_q, msba_q, msbb_q, ovf_q, cout_q;

  logic [1:0]              slice_sum;
  logic                    slice_cout;
  logic [DATA_WIDTH-1:0]   res_d;

  add2_slice u_slice (
    .a_i   (opa_q[1:0]),
    .b_i   (opb_q[1:0]),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  // Sum pairs enter at the top; after STEPS shifts the first pair sits at bit 0.
  assign res_d = {slice_sum, res_q[MSB:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      msba_q  <= 1'b0;
      msbb_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction as A + ~B + 1, with the +1 injected as the initial carry.
            opa_q   <= A;
            opb_q   <= sub ? ~B : B;
            carry_q <= sub;
            cnt_q   <= '0;
            msba_q  <= A[MSB];
            msbb_q  <= sub ? ~B[MSB] : B[MSB];
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_q   <= res_d;
          opa_q   <= opa_q >> 2;
          opb_q   <= opb_q >> 2;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= slice_cout;
            ovf_q   <= (msba_q == msbb_q) && (res_d[MSB] != msba_q);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized and directed check of serial_add_sub against an integer-arithmetic model.
module tb_serial_add_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub, out_valid, out_ready, overflow, cout;
  logic [W-1:0] A, B, result;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  serial_add_sub #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .cout     (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed integer arithmetic, then truncation and range tests.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic ovf, output logic co);
    int sa, sb, sv;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sv  = s ? sa - sb : sa + sb;
    r   = sv[W-1:0];
    ovf = (sv > 32767) || (sv < -32768);
    co  = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
  endtask

  // Issue one request; returns the cycle stamp of its accept edge.
  // With junk=1 in_valid stays high with random operands after the accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic junk, output longint acc);
    logic [W-1:0] er;
    logic         eo, ec;
    int           n;
    A = a; B = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    acc = cyc;
    if (junk) begin
      A = W'($urandom); B = W'($urandom); sub = ~s;
    end else in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n + 1, 9);
    model(a, b, s, er, eo, ec);
    chk("result", result, er);
    chk("overflow", overflow, eo);
    chk("cout", cout, ec);
    if (out_ready) begin
      @(posedge clk); #1;
      chk("one_shot", out_valid, 0);
      chk("hold_idle", result, er);
    end
  endtask

  initial begin
    longint acc, prev;
    logic [W-1:0] er;
    logic         eo, ec;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;

    run_op(16'd5, 16'd3, 1'b1, 1'b0, acc);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, acc);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    run_op(16'h0000, 16'h8000, 1'b1, 1'b0, acc);
    chk("dir_wrap", result, 16'h8000);

    // Backpressure, with stray requests held during BUSY and DONE.
    out_ready = 1'b0;
    run_op(16'h1357, 16'h0246, 1'b0, 1'b1, acc);
    model(16'h1357, 16'h0246, 1'b0, er, eo, ec);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, er);
      chk("bp_cout", cout, ec);
    end
    A = 16'd1; B = 16'd2; sub = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pop", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_result", result, er);
    run_op(16'd1, 16'd2, 1'b0, 1'b0, acc);

    // Reset four cycles into BUSY.
    A = 16'hABCD; B = 16'h1111; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, acc);
    chk("post_rst_sum", result, 16'h2345);

    // Back-to-back random requests with out_ready held high.
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
      if (i > 0) chk("spacing", 32'(acc - prev), 10);
      prev = acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
